// File: rtl/my_interp_filter_gate_pkg.sv
// Shared types and helpers for the linear-interpolating upsampler.
// The accumulator is Q32.16: DATA_W integer bits over FRAC fractional bits.
package interp_pkg;

    localparam int FRAC   = 16;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 48;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, STARVE} interp_state_t;

    // Per-tick increment. The difference is taken at 33 bits so it cannot wrap.
    function automatic logic signed [ACC_W-1:0] calc_step(
        input logic signed [DATA_W-1:0] x_cur,
        input logic signed [DATA_W-1:0] s,
        input int unsigned              shamt
    );
        logic signed [DATA_W:0]  diff;
        logic signed [ACC_W-1:0] ext;
        diff = {s[DATA_W-1], s} - {x_cur[DATA_W-1], x_cur};
        ext  = {{(ACC_W-DATA_W-1){diff[DATA_W]}}, diff};
        return ext <<< shamt;
    endfunction

    function automatic logic signed [ACC_W-1:0] to_acc(input logic signed [DATA_W-1:0] s);
        return {s, {FRAC{1'b0}}};
    endfunction

endpackage

// File: rtl/my_interp_filter_gate.sv
// Linear-interpolating upsampler: ramps from the previous slow sample to the
// newest one over INTERP fast trigs, with one pending slot and a sticky overrun.
module my_interp_filter_gate
    import interp_pkg::*;
#(
    parameter int INTERP = 4,
    parameter int LOG2I  = $clog2(INTERP)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_vld,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     trig,
    output logic signed [DATA_W-1:0] dout,
    output logic                     dout_vld,
    output logic                     overrun,
    output logic [6:0]               monitor_phase
);

    localparam int          PH_W  = (LOG2I == 0) ? 1 : LOG2I;
    localparam int unsigned SHAMT = FRAC - LOG2I;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(INTERP - 1);

    interp_state_t            r_state,    w_state_nxt;
    logic signed [DATA_W-1:0] r_x_cur,    w_x_cur_nxt;
    logic signed [DATA_W-1:0] r_pend,     w_pend_nxt;
    logic                     r_pend_vld, w_pend_vld_nxt;
    logic signed [ACC_W-1:0]  r_step,     w_step_nxt;
    logic signed [ACC_W-1:0]  r_acc,      w_acc_nxt;
    logic [PH_W-1:0]          r_phase,    w_phase_nxt;
    logic signed [DATA_W-1:0] r_dout,     w_dout_nxt;
    logic                     r_dout_vld, w_dout_vld_nxt;
    logic                     r_overrun,  w_overrun_nxt;

    // A fresh sample wins over the pending slot when both could start a segment.
    logic signed [DATA_W-1:0] w_seg_sample;
    logic signed [ACC_W-1:0]  w_seg_step;
    logic signed [ACC_W-1:0]  w_ramp_run;
    logic signed [ACC_W-1:0]  w_ramp_new;
    logic                     w_seg_end;

    assign w_seg_sample = din_vld ? din : r_pend;
    assign w_seg_step   = calc_step(r_x_cur, w_seg_sample, SHAMT);
    assign w_ramp_run   = r_acc + r_step;
    assign w_ramp_new   = r_acc + w_seg_step;
    assign w_seg_end    = trig && (r_phase == LAST_PH);

    always_comb begin
        // NOTE: every next-value gets a default first so no latch is inferred.
        w_state_nxt    = r_state;
        w_x_cur_nxt    = r_x_cur;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_step_nxt     = r_step;
        w_acc_nxt      = r_acc;
        w_phase_nxt    = r_phase;
        w_dout_nxt     = r_dout;
        w_dout_vld_nxt = 1'b0;
        w_overrun_nxt  = r_overrun;

        case (r_state)
            IDLE: begin
                if (din_vld) begin
                    w_x_cur_nxt = din;
                    w_acc_nxt   = to_acc(din);
                    w_state_nxt = PRIME;
                end
            end

            PRIME, STARVE: begin
                w_dout_vld_nxt = trig;
                if (din_vld) begin
                    w_step_nxt  = w_seg_step;
                    w_x_cur_nxt = din;
                    w_phase_nxt = '0;
                    w_state_nxt = RUN;
                    if (trig) begin
                        if (INTERP == 1) begin
                            // A single-tick segment is already complete.
                            w_acc_nxt   = to_acc(din);
                            w_dout_nxt  = din;
                            w_state_nxt = STARVE;
                        end else begin
                            w_acc_nxt   = w_ramp_new;
                            w_dout_nxt  = w_ramp_new[ACC_W-1:FRAC];
                            w_phase_nxt = PH_W'(1);
                        end
                    end
                end else if (trig) begin
                    w_dout_nxt = r_x_cur;
                end
            end

            RUN: begin
                w_dout_vld_nxt = trig;
                if (w_seg_end) begin
                    // Snap to the exact target so rounding never accumulates.
                    w_acc_nxt   = to_acc(r_x_cur);
                    w_dout_nxt  = r_x_cur;
                    w_phase_nxt = '0;
                    if (din_vld || r_pend_vld) begin
                        w_step_nxt     = w_seg_step;
                        w_x_cur_nxt    = w_seg_sample;
                        w_pend_vld_nxt = 1'b0;
                        if (din_vld && r_pend_vld) begin
                            w_overrun_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = STARVE;
                    end
                end else begin
                    if (trig) begin
                        w_acc_nxt   = w_ramp_run;
                        w_dout_nxt  = w_ramp_run[ACC_W-1:FRAC];
                        w_phase_nxt = r_phase + PH_W'(1);
                    end
                    if (din_vld) begin
                        if (r_pend_vld) begin
                            w_overrun_nxt = 1'b1;
                        end
                        w_pend_nxt     = din;
                        w_pend_vld_nxt = 1'b1;
                    end
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state    <= IDLE;
            r_x_cur    <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_step     <= '0;
            r_acc      <= '0;
            r_phase    <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_x_cur    <= w_x_cur_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_step     <= w_step_nxt;
            r_acc      <= w_acc_nxt;
            r_phase    <= w_phase_nxt;
            r_dout     <= w_dout_nxt;
            r_dout_vld <= w_dout_vld_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign dout          = r_dout;
    assign dout_vld      = r_dout_vld;
    assign overrun       = r_overrun;
    assign monitor_phase = 7'(r_phase);

endmodule
